// File: rtl/sifh_event_fifo_if.sv
// Handshake bundle between the TDC front end / histogram FSM side and the
// SiFH event FIFO. The master drives photon events and the histogram ready
// flag; the slave (the FIFO) returns issue pulses, data and status.
interface sifh_event_fifo_if #(
    parameter int NP    = 10,
    parameter int AW    = 4,
    parameter int CNT_W = 16
) ();

    logic             tdc_valid;
    logic [NP-1:0]    tdc_code;
    logic             frame_clr;
    logic             hist_ready;
    logic             wrEn;
    logic [NP-1:0]    data;
    logic [AW:0]      fifo_level;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    modport master (
        output tdc_valid, tdc_code, frame_clr, hist_ready,
        input  wrEn, data, fifo_level, empty, full, evt_cnt, drop_cnt, overflow
    );

    modport slave (
        input  tdc_valid, tdc_code, frame_clr, hist_ready,
        output wrEn, data, fifo_level, empty, full, evt_cnt, drop_cnt, overflow
    );

endinterface

// File: rtl/sifh_event_fifo.sv
// SiFH event FIFO: buffers accepted TDC timestamps and issues them one at a
// time to the histogram FSM as single-cycle wrEn pulses. A three-state issue
// FSM waits for hist_ready to drop and rise again after every issue so the
// lagging ready flag can never cause two issues in one histogram cycle.
// All outputs are registered.
module sifh_event_fifo #(
    parameter int NP    = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TMAX  = 1000,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 res,
    sifh_event_fifo_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_WAIT_HIGH = 2'd2
    } state_t;

    localparam logic [NP-1:0]    CODE_NONE  = {NP{1'b1}};
    localparam logic [NP-1:0]    CODE_LIMIT = NP'(TMAX);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ZERO   = {(AW+1){1'b0}};

    // A timestamp is usable only if present, not the no-photon code, and in range.
    function automatic logic code_ok(input logic valid, input logic [NP-1:0] code);
        return valid && (code != CODE_NONE) && (code < CODE_LIMIT);
    endfunction

    // Saturating increment for the event/drop counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // State registers
    state_t           state_r;
    logic             wr_en_r;
    logic [NP-1:0]    data_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic             empty_r;
    logic             full_r;
    logic [CNT_W-1:0] evt_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             overflow_r;
    logic [NP-1:0]    mem_r [DEPTH];

    // Combinational next-state signals
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             clear_s;
    logic [AW:0]      wr_ptr_nx_s;
    logic [AW:0]      rd_ptr_nx_s;
    logic [NP-1:0]    head_s;

    // Classify this cycle's event and decide push / pop / drop.
    always_comb begin
        accept_s = code_ok(bus.tdc_valid, bus.tdc_code);
        clear_s  = res || bus.frame_clr;
        // empty_r is registered, so an entry pushed this edge is never popped on it.
        pop_s    = (state_r == S_IDLE) && !empty_r && bus.hist_ready;
        push_s   = accept_s && (!full_r || pop_s);
        drop_s   = accept_s && full_r && !pop_s;
        head_s   = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Next pointer values; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
    end

    // Issue FSM: pop head into data with a one-cycle wrEn, then wait for a ready low/high cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r <= S_IDLE;
            wr_en_r <= 1'b0;
            data_r  <= {NP{1'b0}};
        end else if (bus.frame_clr) begin
            // data is intentionally held across an acquisition-window clear
            state_r <= S_IDLE;
            wr_en_r <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        data_r  <= head_s;
                        wr_en_r <= 1'b1;
                        state_r <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!bus.hist_ready) begin
                        state_r <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (bus.hist_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= PTR_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            level_r  <= wr_ptr_nx_s - rd_ptr_nx_s;
            empty_r  <= (wr_ptr_nx_s == rd_ptr_nx_s);
            full_r   <= (wr_ptr_nx_s[AW] != rd_ptr_nx_s[AW]) &&
                        (wr_ptr_nx_s[AW-1:0] == rd_ptr_nx_s[AW-1:0]);
        end
    end

    // Accepted / dropped event statistics and sticky overflow.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            evt_cnt_r  <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                evt_cnt_r <= sat_inc(evt_cnt_r);
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s && !clear_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.tdc_code;
        end
    end

    assign bus.wrEn       = wr_en_r;
    assign bus.data       = data_r;
    assign bus.fifo_level = level_r;
    assign bus.empty      = empty_r;
    assign bus.full       = full_r;
    assign bus.evt_cnt    = evt_cnt_r;
    assign bus.drop_cnt   = drop_cnt_r;
    assign bus.overflow   = overflow_r;

endmodule
